mcu_kwin: RTL and testbench
===========================

Name: mcu_kwin

Overview:
Parametrised memory control unit for the 2D convolution datapath, generalising the fixed 3-row MCU to a K-row kernel, N convolution units and M = N+K-1 line-buffer banks.
- Manages a circular ring of banks with a rotating base index.
- Builds K-tap column windows for each conv unit from bank read data.
- Writes conv results back in place.
- Provides host load and readback paths.
- Sits between the host interface and the bank memories / conv unit array.

Parameters:
N, 2, number of convolution units (>=1)
K, 3, kernel height in rows (>=2)
BITS_IMAGEN, 11, pixel width
BITS_DATA, BITS_IMAGEN, host data width
BITS_ADDR, 10, bank address width
(localparam M = N+K-1 banks; IW = clog2(M) index width)

Ports:
clk  in  1  clock
rst  in  1  reset
i_chblk  in  1  change-block strobe; rising edge counts once
i_sop  in  1  start of processing (level)
i_eop  in  1  end of processing (level)
i_Data  in  BITS_DATA  host pixel to load
i_WAddr  in  BITS_ADDR  write address
i_RAddr  in  BITS_ADDR  read address
i_MemData  in  M*BITS_IMAGEN  bank read data, lane b = bank b
i_DataConv  in  N*BITS_IMAGEN  conv results, lane n = unit n
o_DataConv  out  K*N*BITS_IMAGEN  windows, slice [(n*K+k)*BITS_IMAGEN +: BITS_IMAGEN] = unit n tap k
o_Data  out  BITS_DATA  host readback pixel
o_we  out  M  per-bank write enable
o_WAddr  out  BITS_ADDR  registered i_WAddr
o_RAddr  out  BITS_ADDR  registered i_RAddr
o_MemData  out  M*BITS_IMAGEN  bank write data
o_valid  out  1  o_DataConv valid
o_state  out  2  current state (debug)

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-high. While rst is high:
  - all outputs are 0;
  - state = LOAD;
  - wr_bank = rd_base = rd_sel = 0;
  - chblk edge register = 0.
- All outputs are registered.
- o_WAddr and o_RAddr equal the input value from one cycle earlier, in every state.
- Index arithmetic is modulo M, held in IW bits.
- chblk_evt = i_chblk & ~i_chblk_q. It acts in the current state before any transition that happens in the same cycle.
- State encoding: LOAD=0, RUN=1, READ=2.
- LOAD:
  - o_we = onehot(wr_bank);
  - every o_MemData lane = i_Data;
  - chblk_evt: wr_bank <= wr_bank+1.
  - If i_eop=0 and i_sop=1: go to RUN, with rd_base <= wr_bank+1 (the oldest bank).
- RUN:
  - o_DataConv unit n tap k = i_MemData lane (rd_base+n+k), registered; latency 1 cycle from i_MemData.
  - o_valid = 1 in the cycle after any RUN cycle.
  - While i_sop=1: o_we bit (rd_base+n) = 1 for n = 0..N-1, and o_MemData lane (rd_base+n) = i_DataConv[n]. Other lanes are 0.
  - While i_sop=0: o_we = 0.
  - chblk_evt: rd_base <= rd_base+N.
  - If i_eop=1: go to READ, with rd_sel <= rd_base. i_eop has priority over i_sop.
- READ:
  - o_we = 0; o_valid = 0;
  - o_Data = i_MemData lane rd_sel;
  - chblk_evt: rd_sel <= rd_sel+1.
  - If i_sop=0 and i_eop=0: go to LOAD. wr_bank and rd_base are retained so the ring keeps rotating.
- o_Data is held in LOAD and RUN. o_DataConv is held outside RUN.
- Illegal state encoding 3: go to LOAD on the next clock.
- Reset mid-operation aborts the current state immediately, without waiting for a clock. o_we drops to 0 combinationally through the async clear.

Optional Feature:
MCU_KWIN_OUT_PIPE_EN
- Defined: one extra register stage on o_DataConv, o_valid and o_Data, giving latency 2. Control and o_we timing are unchanged.
- Undefined: latency 1 as above.

Decomposition:
- Package mcu_kwin_pkg holds:
  - state localparams LOAD/RUN/READ and their 2-bit width;
  - a clog2 function;
  - a mod-M add helper.
- One sub-module, mcu_kwin_mux: combinational K*N tap selector from i_MemData and rd_base. It is instanced once; the registering stays in mcu_kwin.

Test Plan (N=2, K=3, M=4, BITS_IMAGEN=11):
- rst=1 for 20 ns mid-clock -> all outputs 0 immediately, o_state=0. After release, next edge: o_we=4'b0001, o_MemData lanes all equal i_Data (11'b01010101010 pattern).
- LOAD, 5 i_chblk pulses of 2 cycles each -> o_we steps 0010, 0100, 1000, 0001, 0010 (wrap, one step per pulse).
- After 5 pulses (wr_bank=1), i_sop=1 -> o_state=1, rd_base=2. With i_MemData lanes 0..3 = 0,1,2,3: o_DataConv unit0 taps = 2,3,0; unit1 taps = 3,0,1; o_valid=1. i_DataConv = {0x7FF,0x155} -> o_we=4'b1100, lane2=0x155, lane3=0x7FF.
- RUN, one i_chblk pulse -> rd_base=0. Unit0 taps 0,1,2; unit1 taps 1,2,3; o_we=4'b0011.
- i_eop=1 while i_sop=1 -> READ (eop wins), o_we=0, o_Data=lane0. Two chblk pulses -> o_Data = lane1, then lane2. Drop both sop and eop -> LOAD with o_we=onehot(1).
- Assert rst mid-RUN -> o_valid, o_we and o_DataConv clear before the next clk edge; state LOAD, wr_bank=0.

Source files
------------

// File: rtl/mcu_kwin_pkg.sv
// mcu_kwin_pkg: shared state encoding and index helpers for the K-row memory control unit.
package mcu_kwin_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {LOAD = 2'd0, RUN = 2'd1, READ = 2'd2} state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int mod_add(input int a, input int b, input int m);
        return (a + b) % m;
    endfunction

endpackage

// File: rtl/mcu_kwin_mux.sv
// mcu_kwin_mux: combinational K-tap column window selector over the rotating bank ring.
module mcu_kwin_mux
    import mcu_kwin_pkg::*;
#(
    parameter int N  = 2,
    parameter int K  = 3,
    parameter int B  = 11,
    parameter int M  = N + K - 1,
    parameter int IW = clog2(M)
) (
    input  logic [M*B-1:0]   mem_data,
    input  logic [IW-1:0]    base,
    output logic [K*N*B-1:0] taps
);

    for (genvar n = 0; n < N; n++) begin : g_n
        for (genvar k = 0; k < K; k++) begin : g_k
            assign taps[(n*K+k)*B +: B] = mem_data[mod_add(int'(base), n + k, M)*B +: B];
        end
    end

endmodule

// File: rtl/mcu_kwin.sv
// mcu_kwin: parametrised memory control unit (bank ring, conv windows, write-back, host load/readback).
// Optional macro MCU_KWIN_OUT_PIPE_EN adds one output register stage on o_DataConv, o_valid and o_Data.
module mcu_kwin
    import mcu_kwin_pkg::*;
#(
    parameter int N           = 2,
    parameter int K           = 3,
    parameter int BITS_IMAGEN = 11,
    parameter int BITS_DATA   = BITS_IMAGEN,
    parameter int BITS_ADDR   = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_chblk,
    input  logic                       i_sop,
    input  logic                       i_eop,
    input  logic [BITS_DATA-1:0]       i_Data,
    input  logic [BITS_ADDR-1:0]       i_WAddr,
    input  logic [BITS_ADDR-1:0]       i_RAddr,
    input  logic [(N+K-1)*BITS_IMAGEN-1:0] i_MemData,
    input  logic [N*BITS_IMAGEN-1:0]   i_DataConv,
    output logic [K*N*BITS_IMAGEN-1:0] o_DataConv,
    output logic [BITS_DATA-1:0]       o_Data,
    output logic [N+K-2:0]             o_we,
    output logic [BITS_ADDR-1:0]       o_WAddr,
    output logic [BITS_ADDR-1:0]       o_RAddr,
    output logic [(N+K-1)*BITS_IMAGEN-1:0] o_MemData,
    output logic                       o_valid,
    output logic [1:0]                 o_state
);

    localparam int M  = N + K - 1;
    localparam int IW = clog2(M);
    localparam int B  = BITS_IMAGEN;

    state_e              state;
    logic [IW-1:0]       wr_bank, rd_base, rd_sel;
    logic                chblk_q, evt;
    logic [K*N*B-1:0]    taps, dc_s;
    logic                valid_s;
    logic [BITS_DATA-1:0] data_s;
    logic [M-1:0]        we_run;
    logic [M*B-1:0]      md_run;

    function automatic logic [IW-1:0] inc(input logic [IW-1:0] a, input int b);
        return IW'(mod_add(int'(a), b, M));
    endfunction

    assign evt     = i_chblk & ~chblk_q;
    assign o_state = state;

    mcu_kwin_mux #(.N(N), .K(K), .B(B), .M(M), .IW(IW)) u_mux (
        .mem_data (i_MemData),
        .base     (rd_base),
        .taps     (taps)
    );

    always_comb begin
        we_run = '0;
        md_run = '0;
        for (int n = 0; n < N; n++) begin
            we_run[mod_add(int'(rd_base), n, M)]        = i_sop;
            md_run[mod_add(int'(rd_base), n, M)*B +: B] = i_sop ? i_DataConv[n*B +: B] : '0;
        end
    end

    // A same-cycle chblk edge is applied before the state hand-off reads the indices.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD;
            wr_bank   <= '0;
            rd_base   <= '0;
            rd_sel    <= '0;
            chblk_q   <= 1'b0;
            o_we      <= '0;
            o_MemData <= '0;
            o_WAddr   <= '0;
            o_RAddr   <= '0;
            dc_s      <= '0;
            valid_s   <= 1'b0;
            data_s    <= '0;
        end else begin
            chblk_q <= i_chblk;
            o_WAddr <= i_WAddr;
            o_RAddr <= i_RAddr;
            case (state)
                LOAD: begin
                    o_we      <= {{(M-1){1'b0}}, 1'b1} << wr_bank;
                    o_MemData <= {M{B'(i_Data)}};
                    valid_s   <= 1'b0;
                    if (evt) wr_bank <= inc(wr_bank, 1);
                    if (!i_eop && i_sop) begin
                        state   <= RUN;
                        rd_base <= inc(wr_bank, evt ? 2 : 1);
                    end
                end
                RUN: begin
                    dc_s      <= taps;
                    valid_s   <= 1'b1;
                    o_we      <= we_run;
                    o_MemData <= md_run;
                    if (evt) rd_base <= inc(rd_base, N);
                    if (i_eop) begin
                        state  <= READ;
                        rd_sel <= inc(rd_base, evt ? N : 0);
                    end
                end
                READ: begin
                    o_we      <= '0;
                    o_MemData <= '0;
                    valid_s   <= 1'b0;
                    data_s    <= BITS_DATA'(i_MemData[int'(rd_sel)*B +: B]);
                    if (evt) rd_sel <= inc(rd_sel, 1);
                    if (!i_sop && !i_eop) state <= LOAD;
                end
                default: begin
                    state     <= LOAD;
                    o_we      <= '0;
                    o_MemData <= '0;
                    valid_s   <= 1'b0;
                end
            endcase
        end
    end

`ifdef MCU_KWIN_OUT_PIPE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_DataConv <= '0;
            o_valid    <= 1'b0;
            o_Data     <= '0;
        end else begin
            o_DataConv <= dc_s;
            o_valid    <= valid_s;
            o_Data     <= data_s;
        end
    end
`else
    assign o_DataConv = dc_s;
    assign o_valid    = valid_s;
    assign o_Data     = data_s;
`endif

endmodule

// File: tb/tb_mcu_kwin.sv
// tb_mcu_kwin: randomized and directed checks of mcu_kwin against a ring-index reference model.
module tb_mcu_kwin;

    localparam int N  = 2;
    localparam int K  = 3;
    localparam int B  = 11;
    localparam int M  = N + K - 1;
    localparam int AW = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             i_chblk = 1'b0, i_sop = 1'b0, i_eop = 1'b0;
    logic [B-1:0]     i_Data = '0;
    logic [AW-1:0]    i_WAddr = '0, i_RAddr = '0;
    logic [M*B-1:0]   i_MemData = '0;
    logic [N*B-1:0]   i_DataConv = '0;
    logic [K*N*B-1:0] o_DataConv;
    logic [B-1:0]     o_Data;
    logic [M-1:0]     o_we;
    logic [AW-1:0]    o_WAddr, o_RAddr;
    logic [M*B-1:0]   o_MemData;
    logic             o_valid;
    logic [1:0]       o_state;

    mcu_kwin #(.N(N), .K(K), .BITS_IMAGEN(B), .BITS_DATA(B), .BITS_ADDR(AW)) dut (
        .clk(clk), .rst(rst), .i_chblk(i_chblk), .i_sop(i_sop), .i_eop(i_eop),
        .i_Data(i_Data), .i_WAddr(i_WAddr), .i_RAddr(i_RAddr), .i_MemData(i_MemData),
        .i_DataConv(i_DataConv), .o_DataConv(o_DataConv), .o_Data(o_Data), .o_we(o_we),
        .o_WAddr(o_WAddr), .o_RAddr(o_RAddr), .o_MemData(o_MemData), .o_valid(o_valid),
        .o_state(o_state)
    );

    always #5 clk = ~clk;

    int compared = 0, mismatched = 0;
    int mem [M];
    int dcv [N];
    bit hold = 0;

    int st, wb, base, sel;
    bit chq;
    logic [K*N*B-1:0] exp_dc;
    logic [M*B-1:0]   exp_md;
    logic [M-1:0]     exp_we;
    logic [B-1:0]     exp_data;
    logic             exp_valid;
    logic [AW-1:0]    exp_wa, exp_ra;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        st = 0; wb = 0; base = 0; sel = 0; chq = 0;
        exp_dc = '0; exp_md = '0; exp_we = '0; exp_data = '0; exp_valid = 0;
        exp_wa = '0; exp_ra = '0;
    endtask

    task automatic drive();
        for (int b = 0; b < M; b++) i_MemData[b*B +: B] = B'(mem[b]);
        for (int n = 0; n < N; n++) i_DataConv[n*B +: B] = B'(dcv[n]);
    endtask

    task automatic model();
        bit evt;
        evt = i_chblk && !chq;
        exp_wa = i_WAddr;
        exp_ra = i_RAddr;
        if (st == 0) begin
            exp_we = '0;
            exp_we[wb] = 1'b1;
            for (int b = 0; b < M; b++) exp_md[b*B +: B] = i_Data;
            exp_valid = 0;
            if (evt) wb = (wb + 1) % M;
            if (!i_eop && i_sop) begin st = 1; base = (wb + 1) % M; end
        end else if (st == 1) begin
            for (int n = 0; n < N; n++)
                for (int k = 0; k < K; k++) exp_dc[(n*K+k)*B +: B] = B'(mem[(base+n+k)%M]);
            exp_valid = 1;
            exp_we = '0;
            exp_md = '0;
            if (i_sop)
                for (int n = 0; n < N; n++) begin
                    exp_we[(base+n)%M] = 1'b1;
                    exp_md[((base+n)%M)*B +: B] = B'(dcv[n]);
                end
            if (evt) base = (base + N) % M;
            if (i_eop) begin st = 2; sel = base; end
        end else begin
            exp_we = '0;
            exp_md = '0;
            exp_valid = 0;
            exp_data = B'(mem[sel]);
            if (evt) sel = (sel + 1) % M;
            if (!i_sop && !i_eop) st = 0;
        end
        chq = i_chblk;
    endtask

    task automatic check_all();
        chk("state", 128'(o_state), 128'(st));
        chk("we", 128'(o_we), 128'(exp_we));
        chk("memdata", 128'(o_MemData), 128'(exp_md));
        chk("valid", 128'(o_valid), 128'(exp_valid));
        chk("dataconv", 128'(o_DataConv), 128'(exp_dc));
        chk("data", 128'(o_Data), 128'(exp_data));
        chk("waddr", 128'(o_WAddr), 128'(exp_wa));
        chk("raddr", 128'(o_RAddr), 128'(exp_ra));
    endtask

    task automatic cyc();
        if (!hold) begin
            for (int b = 0; b < M; b++) mem[b] = int'($urandom_range(0, 2047));
            for (int n = 0; n < N; n++) dcv[n] = int'($urandom_range(0, 2047));
            i_Data  = B'($urandom);
            i_WAddr = AW'($urandom);
            i_RAddr = AW'($urandom);
        end
        drive();
        @(posedge clk);
        model();
        #1;
        check_all();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_we"}, 128'(o_we), 128'(0));
        chk({tag, "_valid"}, 128'(o_valid), 128'(0));
        chk({tag, "_dc"}, 128'(o_DataConv), 128'(0));
        chk({tag, "_md"}, 128'(o_MemData), 128'(0));
        chk({tag, "_state"}, 128'(o_state), 128'(0));
        chk({tag, "_data"}, 128'(o_Data), 128'(0));
    endtask

    task automatic fixed_lanes(input int off);
        for (int b = 0; b < M; b++) mem[b] = b + off;
        dcv[0] = 'h155;
        dcv[1] = 'h7FF;
    endtask

    initial begin
        model_reset();
        // Reset asserted mid-clock: outputs clear without a clock edge
        #2 rst = 1'b1;
        #1 check_zero("rst_async");
        #19 rst = 1'b0;
        hold = 1;
        i_Data = 11'b01010101010;
        cyc();
        chk("first_we", 128'(o_we), 128'(4'b0001));
        hold = 0;
        for (int p = 0; p < 5; p++) begin
            i_chblk = 1'b1; cyc(); cyc();
            chk("load_step", 128'(o_we), 128'((1 << ((p + 1) % M)) & 4'hF));
            i_chblk = 1'b0; cyc();
        end
        hold = 1;
        fixed_lanes(0);
        i_sop = 1'b1; cyc();
        chk("to_run", 128'(o_state), 128'(1));
        cyc();
        chk("run_taps_b2", 128'(o_DataConv), 128'({11'd1, 11'd0, 11'd3, 11'd0, 11'd3, 11'd2}));
        chk("run_we_b2", 128'(o_we), 128'(4'b1100));
        chk("run_md_b2", 128'(o_MemData), 128'({11'h7FF, 11'h155, 11'd0, 11'd0}));
        chk("run_valid", 128'(o_valid), 128'(1));
        i_chblk = 1'b1; cyc();
        i_chblk = 1'b0; cyc();
        chk("run_taps_b0", 128'(o_DataConv), 128'({11'd3, 11'd2, 11'd1, 11'd2, 11'd1, 11'd0}));
        chk("run_we_b0", 128'(o_we), 128'(4'b0011));
        hold = 0;
        for (int i = 0; i < 6; i++) begin
            i_sop = 1'($urandom); cyc();
        end
        hold = 1;
        fixed_lanes(0);
        i_sop = 1'b1; i_eop = 1'b1; cyc();
        chk("eop_wins", 128'(o_state), 128'(2));
        cyc();
        chk("read_lane0", 128'(o_Data), 128'(0));
        chk("read_we", 128'(o_we), 128'(0));
        for (int p = 1; p <= 2; p++) begin
            i_chblk = 1'b1; cyc();
            i_chblk = 1'b0; cyc();
            chk("read_lane", 128'(o_Data), 128'(p));
        end
        i_sop = 1'b0; i_eop = 1'b0; cyc();
        chk("back_load", 128'(o_state), 128'(0));
        cyc();
        chk("load_retained", 128'(o_we), 128'(4'b0010));
        hold = 0;
        for (int i = 0; i < 300; i++) begin
            i_chblk = ($urandom_range(0, 3) == 0);
            i_sop   = ($urandom_range(0, 2) != 0);
            i_eop   = ($urandom_range(0, 4) == 0);
            cyc();
        end
        // Steer into RUN, then abort with reset between edges
        i_chblk = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
        cyc(); cyc();
        i_sop = 1'b1;
        cyc(); cyc();
        hold = 1;
        fixed_lanes(1);
        cyc();
        chk("pre_rst_valid", 128'(o_valid), 128'(1));
        #2 rst = 1'b1;
        #1 check_zero("rst_midrun");
        model_reset();
        i_sop = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        cyc();
        chk("post_rst_we", 128'(o_we), 128'(4'b0001));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
